// File: rtl/note_grid_renderer.sv
// Note-grid renderer: COLS x ROWS grid of 24-bit cell colours edited by place/delete
// commands, cleared by a one-column-per-cycle sweep, and scanned into a registered pixel colour.
module note_grid_renderer #(
    parameter int          COLS       = 40,
    parameter int          ROWS       = 12,
    parameter int          X_OFF      = 64,
    parameter int          Y_OFF      = 29,
    parameter int          CELL_W     = 22,
    parameter int          CELL_H     = 35,
    parameter logic [23:0] CURSOR_RGB = 24'h303030
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      place,
    input  logic                      delete,
    input  logic                      clear,
    input  logic                      chord,
    input  logic [$clog2(COLS)-1:0]   col,
    input  logic [5:0]                note,
    input  logic [23:0]               note_rgb,
    input  logic                      play_en,
    input  logic [$clog2(COLS)-1:0]   play_col,
    input  logic [9:0]                x,
    input  logic [8:0]                y,
    input  logic [23:0]               bg_rgb,
    output logic [23:0]               color,
    output logic                      busy,
    output logic                      state_dbg_o
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int GRID_X = X_OFF + COLS * CELL_W;
    localparam int GRID_Y = Y_OFF + ROWS * CELL_H;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [COL_W-1:0]  sweep_q;
    logic              busy_q;
    logic [23:0]       color_q;
    logic [23:0]       color_d;
    logic [23:0]       cells_q [COLS][ROWS];

    // Commands are single-cycle pulses with no handshake: they are acted on only
    // in S_IDLE with reset low, otherwise dropped. Priority reset > clear > delete > place.
    logic             accept;
    logic             col_ok;
    logic             do_delete;
    logic             do_place;
    logic [ROW_W-1:0] note_row;

    assign accept    = (state_q == S_IDLE) && !reset;
    assign col_ok    = int'(col) < COLS;
    assign do_delete = accept && !clear && delete && col_ok;
    assign do_place  = accept && !clear && !delete && place && col_ok;
    assign note_row  = ROW_W'(int'(note) % ROWS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
            sweep_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        state_q <= S_CLEAR;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (int'(sweep_q) == COLS - 1) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        sweep_q <= sweep_q + COL_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Cell storage carries no reset; the sweep started by reset defines its contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                for (int r = 0; r < ROWS; r++) begin
                    cells_q[sweep_q][r] <= '0;
                end
            end else if (do_delete) begin
                if (chord) begin
                    cells_q[col][note_row] <= '0;
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        cells_q[col][r] <= '0;
                    end
                end
            end else if (do_place) begin
                if (chord) begin
                    cells_q[col][note_row] <= note_rgb;
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        cells_q[col][r] <= (r == int'(note_row)) ? note_rgb : 24'h0;
                    end
                end
            end
        end
    end

    logic [31:0]      x_rel;
    logic [31:0]      y_rel;
    logic             in_grid;
    logic [COL_W-1:0] cx;
    logic [ROW_W-1:0] cy;
    logic [23:0]      cell_rgb;
    logic             cursor_hit;

    // Offsets are formed in 32 bits so neither subtraction nor division truncates.
    always_comb begin
        x_rel    = 32'(x) - 32'(X_OFF);
        y_rel    = 32'(y) - 32'(Y_OFF);
        in_grid  = (32'(x) >= 32'(X_OFF)) && (32'(x) < 32'(GRID_X)) &&
                   (32'(y) >= 32'(Y_OFF)) && (32'(y) < 32'(GRID_Y));
        cx       = '0;
        cy       = '0;
        if (in_grid) begin
            cx = COL_W'(x_rel / 32'(CELL_W));
            cy = ROW_W'(y_rel / 32'(CELL_H));
        end
        cell_rgb   = cells_q[cx][cy];
        cursor_hit = play_en && (int'(play_col) < COLS) && (play_col == cx);
        if (!in_grid) begin
            color_d = bg_rgb;
        end else if (cell_rgb != 24'h0) begin
            color_d = cell_rgb;
        end else if (cursor_hit) begin
            color_d = CURSOR_RGB;
        end else begin
            color_d = 24'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            color_q <= '0;
        end else begin
            color_q <= color_d;
        end
    end

    assign color       = color_q;
    assign busy        = busy_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_note_grid_renderer.sv
// Directed bench for note_grid_renderer: vector table for pixel lookups plus
// hand-written sequences for sweep timing, dropped commands and mid-sweep reset.
module tb_note_grid_renderer;

  logic        clk = 1'b0;
  logic        reset, place, delete, clear, chord, play_en;
  logic [5:0]  col, play_col, note;
  logic [23:0] note_rgb, bg_rgb, color;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        busy, state_dbg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  note_grid_renderer dut (
    .clk(clk), .reset(reset), .place(place), .delete(delete), .clear(clear),
    .chord(chord), .col(col), .note(note), .note_rgb(note_rgb),
    .play_en(play_en), .play_col(play_col), .x(x), .y(y), .bg_rgb(bg_rgb),
    .color(color), .busy(busy), .state_dbg_o(state_dbg)
  );

  typedef struct {
    logic [9:0]  px;
    logic [8:0]  py;
    logic [23:0] bg;
    logic        pe;
    logic [5:0]  pc;
    logic [23:0] exp_v;
  } vec_t;

  vec_t vecs[28];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp_v);
    end
  endtask

  task automatic chk_pix(input string name, input logic [9:0] px, input logic [8:0] py,
                         input logic [23:0] bg, input logic pe, input logic [5:0] pc,
                         input logic [23:0] exp_v);
    x = px; y = py; bg_rgb = bg; play_en = pe; play_col = pc;
    tick();
    check(name, color, exp_v);
  endtask

  task automatic cmd(input logic p, input logic d, input logic ch, input logic [5:0] c,
                     input logic [5:0] n, input logic [23:0] rgb);
    place = p; delete = d; chord = ch; col = c; note = n; note_rgb = rgb;
    tick();
    place = 1'b0; delete = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Grid at table time: col3 row2 FF0000, col5 row7 00FF00, col39 row3 ABCDEF.
    vecs[0]  = '{10'd10,   9'd10,  24'h123456, 1'b0, 6'd0,  24'h123456};
    vecs[1]  = '{10'd63,   9'd99,  24'h0A0B0C, 1'b0, 6'd0,  24'h0A0B0C};
    vecs[2]  = '{10'd64,   9'd29,  24'h111111, 1'b0, 6'd0,  24'h000000};
    vecs[3]  = '{10'd130,  9'd99,  24'h111111, 1'b0, 6'd0,  24'hFF0000};
    vecs[4]  = '{10'd151,  9'd133, 24'h111111, 1'b0, 6'd0,  24'hFF0000};
    vecs[5]  = '{10'd152,  9'd99,  24'h111111, 1'b0, 6'd0,  24'h000000};
    vecs[6]  = '{10'd130,  9'd134, 24'h111111, 1'b0, 6'd0,  24'h000000};
    vecs[7]  = '{10'd130,  9'd29,  24'h111111, 1'b0, 6'd0,  24'h000000};
    vecs[8]  = '{10'd174,  9'd274, 24'h111111, 1'b0, 6'd0,  24'h00FF00};
    vecs[9]  = '{10'd174,  9'd29,  24'h111111, 1'b0, 6'd0,  24'h000000};
    vecs[10] = '{10'd922,  9'd134, 24'h111111, 1'b0, 6'd0,  24'hABCDEF};
    vecs[11] = '{10'd943,  9'd168, 24'h111111, 1'b0, 6'd0,  24'hABCDEF};
    vecs[12] = '{10'd944,  9'd134, 24'h000777, 1'b0, 6'd0,  24'h000777};
    vecs[13] = '{10'd921,  9'd134, 24'h111111, 1'b0, 6'd0,  24'h000000};
    vecs[14] = '{10'd130,  9'd28,  24'h222222, 1'b0, 6'd0,  24'h222222};
    vecs[15] = '{10'd943,  9'd448, 24'h333333, 1'b0, 6'd0,  24'h000000};
    vecs[16] = '{10'd943,  9'd449, 24'h444444, 1'b0, 6'd0,  24'h444444};
    vecs[17] = '{10'd174,  9'd29,  24'h111111, 1'b1, 6'd5,  24'h303030};
    vecs[18] = '{10'd174,  9'd274, 24'h111111, 1'b1, 6'd5,  24'h00FF00};
    vecs[19] = '{10'd174,  9'd448, 24'h111111, 1'b1, 6'd5,  24'h303030};
    vecs[20] = '{10'd130,  9'd29,  24'h111111, 1'b1, 6'd5,  24'h000000};
    vecs[21] = '{10'd10,   9'd10,  24'h010203, 1'b1, 6'd5,  24'h010203};
    vecs[22] = '{10'd174,  9'd29,  24'h111111, 1'b1, 6'd40, 24'h000000};
    vecs[23] = '{10'd174,  9'd29,  24'h111111, 1'b0, 6'd5,  24'h000000};
    vecs[24] = '{10'd130,  9'd99,  24'h111111, 1'b1, 6'd3,  24'hFF0000};
    vecs[25] = '{10'd152,  9'd29,  24'h111111, 1'b1, 6'd4,  24'h303030};
    vecs[26] = '{10'd151,  9'd29,  24'h111111, 1'b1, 6'd4,  24'h000000};
    vecs[27] = '{10'd1023, 9'd511, 24'hFEDCBA, 1'b1, 6'd39, 24'hFEDCBA};

    reset = 1'b1; place = 1'b0; delete = 1'b0; clear = 1'b0; chord = 1'b0;
    col = '0; note = '0; note_rgb = '0; play_en = 1'b0; play_col = '0;
    x = '0; y = '0; bg_rgb = '0;

    // Reset and power-on sweep
    tick();
    reset = 1'b0;
    check("reset_color", color, 24'h0);
    check("reset_busy", 24'(busy), 24'd1);
    count_busy(n);
    check("reset_sweep_len", 24'(n), 24'd40);
    for (int i = 0; i < 5; i++) begin
      chk_pix("empty_cell", 10'(64 + i * 200), 9'(29 + i * 100), 24'hFFFFFF, 1'b0, 6'd0, 24'h0);
    end
    chk_pix("bg_10_10", 10'd10, 9'd10, 24'h123456, 1'b0, 6'd0, 24'h123456);

    // Whole-column place replaces earlier chord cell
    cmd(1'b1, 1'b0, 1'b1, 6'd3, 6'd0, 24'h00FF00);
    chk_pix("chord_col3_r0", 10'd130, 9'd29, 24'h0, 1'b0, 6'd0, 24'h00FF00);
    cmd(1'b1, 1'b0, 1'b0, 6'd3, 6'd14, 24'hFF0000);
    chk_pix("place_col3_r2", 10'd130, 9'd99, 24'h0, 1'b0, 6'd0, 24'hFF0000);
    chk_pix("place_col3_r0", 10'd130, 9'd29, 24'h0, 1'b0, 6'd0, 24'h0);

    // Chord editing on col 5
    cmd(1'b1, 1'b0, 1'b1, 6'd5, 6'd0, 24'h0000FF);
    cmd(1'b1, 1'b0, 1'b1, 6'd5, 6'd7, 24'h00FF00);
    chk_pix("chord5_r0", 10'd174, 9'd29, 24'h0, 1'b0, 6'd0, 24'h0000FF);
    chk_pix("chord5_r7", 10'd174, 9'd274, 24'h0, 1'b0, 6'd0, 24'h00FF00);
    cmd(1'b0, 1'b1, 1'b1, 6'd5, 6'd0, 24'h0);
    chk_pix("chord_del5_r0", 10'd174, 9'd29, 24'h0, 1'b0, 6'd0, 24'h0);
    chk_pix("chord_del5_r7", 10'd174, 9'd274, 24'h0, 1'b0, 6'd0, 24'h00FF00);
    cmd(1'b1, 1'b0, 1'b1, 6'd39, 6'd63, 24'hABCDEF);

    for (int i = 0; i < 28; i++) begin
      chk_pix($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].bg,
              vecs[i].pe, vecs[i].pc, vecs[i].exp_v);
    end
    play_en = 1'b0;

    // Whole-column delete
    cmd(1'b0, 1'b1, 1'b0, 6'd5, 6'd0, 24'h0);
    chk_pix("del5_r7", 10'd174, 9'd274, 24'h0, 1'b0, 6'd0, 24'h0);
    chk_pix("del5_keeps39", 10'd922, 9'd134, 24'h0, 1'b0, 6'd0, 24'hABCDEF);

    // Dropped commands: out-of-range column, place+delete together
    cmd(1'b1, 1'b0, 1'b0, 6'd2, 6'd4, 24'h111111);
    chk_pix("fill_col2", 10'd108, 9'd169, 24'h0, 1'b0, 6'd0, 24'h111111);
    cmd(1'b1, 1'b0, 1'b0, 6'd40, 6'd4, 24'h404040);
    chk_pix("col40_keeps2", 10'd108, 9'd169, 24'h0, 1'b0, 6'd0, 24'h111111);
    chk_pix("col40_keeps39", 10'd922, 9'd134, 24'h0, 1'b0, 6'd0, 24'hABCDEF);
    cmd(1'b1, 1'b1, 1'b0, 6'd2, 6'd4, 24'h999999);
    chk_pix("pd_col2_cleared", 10'd108, 9'd169, 24'h0, 1'b0, 6'd0, 24'h0);
    chk_pix("pd_col3_kept", 10'd130, 9'd99, 24'h0, 1'b0, 6'd0, 24'hFF0000);

    // Clear pulse; clear and place during the sweep are dropped
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy_rise", 24'(busy), 24'd1);
    n = 0;
    while (busy && n < 200) begin
      clear = (n == 10);
      if (n == 20) begin
        place = 1'b1; chord = 1'b0; col = 6'd7; note = 6'd0; note_rgb = 24'h777777;
      end else begin
        place = 1'b0;
      end
      tick();
      n++;
    end
    clear = 1'b0; place = 1'b0;
    check("clear_sweep_len", 24'(n), 24'd40);
    chk_pix("busy_place_dropped", 10'd218, 9'd29, 24'h0, 1'b0, 6'd0, 24'h0);
    chk_pix("clear_col39", 10'd922, 9'd134, 24'h0, 1'b0, 6'd0, 24'h0);
    chk_pix("clear_col3", 10'd130, 9'd99, 24'h0, 1'b0, 6'd0, 24'h0);

    // Reset on the 10th sweep cycle restarts the sweep
    cmd(1'b1, 1'b0, 1'b0, 6'd20, 6'd0, 24'h202020);
    chk_pix("fill_col20", 10'd504, 9'd29, 24'h0, 1'b0, 6'd0, 24'h202020);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_color", color, 24'h0);
    check("midreset_busy", 24'(busy), 24'd1);
    count_busy(n);
    check("midreset_sweep_len", 24'(n), 24'd40);
    chk_pix("midreset_col20", 10'd504, 9'd29, 24'h0, 1'b0, 6'd0, 24'h0);
    chk_pix("midreset_col0", 10'd64, 9'd29, 24'h0, 1'b0, 6'd0, 24'h0);
    chk_pix("midreset_corner", 10'd943, 9'd448, 24'h0, 1'b0, 6'd0, 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_grid_renderer.md
# note_grid_renderer

Parametrised note-grid renderer for the VGA composition display. It holds a COLS×ROWS grid of 24-bit cell colours, updated by place/delete commands from the user I/O path. It supports single-note and chord (multi-row per column) editing, a self-timed clear sweep with busy indication, and a playback-cursor column highlight. Each cycle it converts the video driver's scan coordinates into a registered pixel colour, falling back to the externally supplied background/label colour outside the grid.

## Interface
- COLS, 40, number of time columns
- ROWS, 12, number of pitch rows; note row = note % ROWS
- X_OFF, 64, x pixel of grid's left edge
- Y_OFF, 29, y pixel of grid's top edge
- CELL_W, 22, cell width in pixels
- CELL_H, 35, cell height in pixels
- CURSOR_RGB, 24'h303030, fill colour for empty cells in the cursor column
- clk  in  1  clock
- reset  in  1  synchronous, active-high; starts a full clear sweep
- place  in  1  one-cycle pulse: write note_rgb at (col, note % ROWS)
- delete  in  1  one-cycle pulse: erase at col
- clear  in  1  one-cycle pulse: start clear sweep without reset
- chord  in  1  qualifies place/delete: 1 = single-cell edit, 0 = whole-column edit
- col  in  $clog2(COLS)  target column
- note  in  6  target note number
- note_rgb  in  24  colour for the placed note
- play_en  in  1  enable cursor highlight
- play_col  in  $clog2(COLS)  cursor column
- x  in  10  scan x
- y  in  9  scan y
- bg_rgb  in  24  background/label colour for the current x,y
- color  out  24  registered pixel colour
- busy  out  1  high while the clear sweep runs

## Operation
- Storage: COLS×ROWS×24-bit cells; 0 means empty.
- FSM states S_IDLE and S_CLEAR.
  - reset or clear: go to S_CLEAR with sweep counter = 0.
  - In S_CLEAR, each cycle with reset low: zero all ROWS cells of column sweep_cnt, then increment.
  - When sweep_cnt == COLS-1 is cleared, go to S_IDLE.
- busy = (state == S_CLEAR).
- Command priority per cycle: reset > clear > delete > place.
- place, chord=0: column col becomes note_rgb at row note % ROWS and 0 elsewhere.
- place, chord=1: only cell (col, note % ROWS) is written; other rows are kept.
- delete, chord=0: all cells of col are zeroed.
- delete, chord=1: only cell (col, note % ROWS) is zeroed.
- Ignored commands:
  - place/delete with col ≥ COLS.
  - place/delete/clear while busy (dropped, not queued).
  - place and delete in the same cycle: delete executes, place is dropped.
- Pixel mapping:
  - in_grid = X_OFF ≤ x < X_OFF+COLS·CELL_W and Y_OFF ≤ y < Y_OFF+ROWS·CELL_H.
  - cx = (x−X_OFF)/CELL_W; cy = (y−Y_OFF)/CELL_H; use unsigned arithmetic wide enough for no truncation.
  - Colour select, in priority order:
    - in_grid and cell(cx,cy) ≠ 0: cell colour.
    - in_grid, cell empty, play_en, cx == play_col: CURSOR_RGB.
    - in_grid otherwise: 0.
    - outside grid: bg_rgb.
- play_col ≥ COLS highlights nothing.

## Timing
- Reset values: color = 0, busy = 1 in the cycle after reset is sampled.
- Memory contents are undefined until the sweep completes.
- Sweep after reset release: busy stays high exactly COLS cycles, then falls.
- clear pulse in S_IDLE: busy rises next cycle and stays high COLS cycles.
- reset asserted mid-sweep: sweep restarts at column 0.
- Edits: a write on cycle n is visible to a pixel lookup presented on cycle n+1.
- color latency: one cycle from x, y, bg_rgb, play_en, play_col to color.
- No combinational path from inputs to color.

## Test plan
- Reset 1 cycle, then hold idle: busy high 40 cycles, then low; every in-grid pixel reads 0; (x=10, y=10) returns bg_rgb one cycle later.
- place col=3, note=14, rgb=FF0000, chord=0, then scan (x=64+3·22, y=29+2·35): color = FF0000; row 0 of col 3 reads 0.
- Chord: place col=5, note=0, chord=1 and place col=5, note=7, chord=1 → both cells show their colours. delete col=5, note=0, chord=1 → only row 0 is cleared. delete chord=0 → whole column reads 0.
- play_en=1, play_col=5 → empty col-5 cells read 303030 and occupied cells keep their colour. play_col=40 → no highlight anywhere.
- Dropped commands: place during busy, place with col=40, and same-cycle place+delete on col 2 (previously filled) → grid unchanged except col 2, which is cleared.
- Assert reset on the 10th sweep cycle → busy stays high for a further 40 cycles after release; all cells read 0.
